// File: rtl/alu_div_ctrl.sv
// alu_div_ctrl: RV32M restoring-divide sequencer (DIV/DIVU/REM/REMU) driving the divider unit.
// Optional ALU_DIV_EARLY_OUT_EN: finish straight from LOAD when |a| < |b|.
module alu_div_ctrl #(
  parameter int W = 32,
  parameter int C = 6
) (
  input  logic           clk,
  input  logic           a_rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [W-1:0]   resp_data,
  output logic           busy,
  output logic           load,
  output logic           dact,
  output logic           div_res_sel,
  output logic [1:0]     div_sbit,
  output logic           div_zero,
  output logic           div_overflow,
  output logic [2*W+4:0] accum,
  input  logic           div_done,
  input  logic [W-1:0]   div_result
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  if ((1 << C) <= W) begin : g_c_check
    $error("alu_div_ctrl: C too narrow for W");
  end
  state_t state_q, state_d;
  logic [1:0] op_q, op_d, sbit_q, sbit_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, amag, bmag;
  logic [W:0] rem_q, rem_d, sh, sub;
  logic zero_q, zero_d, ovf_q, ovf_d, early_q, early_d;
  logic ready_q, ready_d, valid_q, valid_d, busy_q, busy_d, load_q, load_d, dact_q, dact_d;
  logic sgn, sa, sb, zero, ovf, early, ge, fast;
  always_comb begin
    sgn = ~req_op[0];
    sa = sgn & req_a[W-1];
    sb = sgn & req_b[W-1];
    amag = sa ? -req_a : req_a;
    bmag = sb ? -req_b : req_b;
    zero = req_b == '0;
    ovf = sgn & (req_a == MIN_NEG) & (&req_b);
`ifdef ALU_DIV_EARLY_OUT_EN
    early = ~zero & ~ovf & (amag < bmag);
`else
    early = 1'b0;
`endif
    fast = zero_q | ovf_q | early_q;
    // one restoring step: shift in the next dividend bit, subtract |b| if it fits
    sh = {rem_q[W-1:0], quo_q[W-1]};
    ge = sh >= {1'b0, b_q};
    sub = sh - {1'b0, b_q};
    state_d = state_q;
    op_d = op_q;
    sbit_d = sbit_q;
    a_d = a_q;
    b_d = b_q;
    quo_d = quo_q;
    rem_d = rem_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    early_d = early_q;
    ready_d = ready_q;
    valid_d = valid_q;
    busy_d = busy_q;
    load_d = load_q;
    dact_d = dact_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = LOAD;
        op_d = req_op;
        a_d = req_a;
        b_d = bmag;
        sbit_d = {sa, sa ^ sb};
        zero_d = zero;
        ovf_d = ovf;
        early_d = early;
        rem_d = '0;
        quo_d = amag;
        load_d = ~early;
        dact_d = 1'b1;
        ready_d = 1'b0;
        busy_d = 1'b1;
      end
      LOAD: begin
        state_d = fast ? DONE : RUN;
        load_d = 1'b0;
        dact_d = ~fast;
        valid_d = fast;
      end
      RUN: begin
        rem_d = ge ? sub : sh;
        quo_d = {quo_q[W-2:0], ge};
        if (div_done) begin
          state_d = DONE;
          dact_d = 1'b0;
          valid_d = 1'b1;
        end
      end
      DONE: if (resp_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d = 1'b0;
        ready_d = 1'b1;
        sbit_d = '0;
        zero_d = 1'b0;
        ovf_d = 1'b0;
        early_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (a_rst) begin
      state_q <= IDLE;
      op_q <= '0;
      sbit_q <= '0;
      a_q <= '0;
      b_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      early_q <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      load_q <= 1'b0;
      dact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      sbit_q <= sbit_d;
      a_q <= a_d;
      b_q <= b_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      early_q <= early_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      load_q <= load_d;
      dact_q <= dact_d;
    end
  end
  assign req_ready = ready_q;
  assign resp_valid = valid_q;
  assign busy = busy_q;
  assign load = load_q;
  assign dact = dact_q;
  assign div_res_sel = op_q[1];
  assign div_sbit = sbit_q;
  assign div_zero = zero_q;
  assign div_overflow = ovf_q;
  assign accum = {rem_q, 1'b0, quo_q, 3'b000};
  assign resp_data = state_q != DONE ? '0 :
                     zero_q ? (op_q[1] ? a_q : '1) :
                     ovf_q ? (op_q[1] ? '0 : MIN_NEG) :
                     early_q ? (op_q[1] ? a_q : '0) : div_result;
endmodule

// File: tb/tb_alu_div_ctrl.sv
// tb_alu_div_ctrl: directed checks of the divide sequencer with a behavioural divider unit.
module tb_alu_div_ctrl;
  localparam int W = 32;
`ifdef ALU_DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
  localparam logic EARLY_LOAD = 1'b0;
`else
  localparam int EARLY_LAT = 33;
  localparam logic EARLY_LOAD = 1'b1;
`endif
  logic clk = 1'b0;
  logic a_rst = 1'b1;
  logic req_valid = 1'b0;
  logic resp_ready = 1'b0;
  logic [1:0] req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic req_ready, resp_valid, busy, load, dact, div_res_sel, div_zero, div_overflow, div_done;
  logic [1:0] div_sbit;
  logic [W-1:0] resp_data, div_result, quo, rem;
  logic [2*W+4:0] accum;
  logic [5:0] cnt;
  int cyc = 0;
  int t_acc = 0;
  int t_ack = 0;
  int checks = 0;
  int errors = 0;

  alu_div_ctrl #(.W(W), .C(6)) dut (
    .clk(clk), .a_rst(a_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy),
    .load(load), .dact(dact), .div_res_sel(div_res_sel), .div_sbit(div_sbit),
    .div_zero(div_zero), .div_overflow(div_overflow), .accum(accum),
    .div_done(div_done), .div_result(div_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // divider unit: iteration counter and sign correction of the frozen accumulator
  always @(posedge clk) cnt <= (a_rst | load) ? 6'd0 : dact ? cnt + 6'd1 : cnt;
  assign quo = accum[W+2:3];
  assign rem = accum[2*W+3:W+4];
  assign div_done = dact & ~load & (cnt == 6'(W-1));
  assign div_result = div_res_sel ? (div_sbit[1] ? -rem : rem) : (div_sbit[0] ? -quo : quo);

  task automatic chk(input string tag, input logic [2*W+4:0] obs, input logic [2*W+4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic get_resp(input string tag, input int lat, input logic [W-1:0] data);
    while (!resp_valid && cyc - t_acc < 100) @(negedge clk);
    chk({tag, "_lat"}, cyc - t_acc, lat);
    chk({tag, "_data"}, resp_data, data);
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    t_ack = cyc;
    chk("ack_valid", resp_valid, 1'b0);
    chk("ack_ready", req_ready, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_load_dact", {load, dact}, 2'b00);
    chk("rst_accum", accum, '0);
    chk("rst_data", resp_data, '0);
    // DIV 20 / -3 = -6
    send(2'b00, 32'd20, 32'hFFFF_FFFD);
    chk("div_load", {load, dact, busy, req_ready}, 4'b1110);
    chk("div_sbit_load", div_sbit, 2'b01);
    chk("div_accum_init", accum, 69'd160);
    repeat (5) @(negedge clk);
    chk("div_run", {load, dact, div_sbit}, 4'b0101);
    get_resp("div", 33, 32'hFFFF_FFFA);
    chk("div_done_ctl", {dact, div_sbit, div_res_sel}, 4'b0010);
    chk("div_accum_final", accum, 69'h20_0000_0030);
    ack();
    // REM -20 % 3 = -2
    send(2'b10, 32'hFFFF_FFEC, 32'd3);
    chk("rem_sbit", {div_sbit, div_res_sel}, 3'b111);
    get_resp("rem", 33, 32'hFFFF_FFFE);
    ack();
    // REMU 0xFFFFFFFF % 10 = 5
    send(2'b11, 32'hFFFF_FFFF, 32'd10);
    chk("remu_sbit", div_sbit, 2'b00);
    get_resp("remu", 33, 32'd5);
    ack();
    // divide by zero
    send(2'b01, 32'd7, 32'd0);
    chk("divu_z_flags", {div_zero, div_overflow, load}, 3'b101);
    get_resp("divu_z", 1, 32'hFFFF_FFFF);
    ack();
    chk("divu_z_clear", div_zero, 1'b0);
    send(2'b10, 32'd7, 32'd0);
    get_resp("rem_z", 1, 32'd7);
    ack();
    // signed overflow
    send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_flags", {div_zero, div_overflow}, 2'b01);
    get_resp("div_ovf", 1, 32'h8000_0000);
    ack();
    send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    get_resp("rem_ovf", 1, 32'd0);
    ack();
    chk("ovf_clear", div_overflow, 1'b0);
    // DIVU 100 / 7 with back-pressure, then back-to-back request
    send(2'b01, 32'd100, 32'd7);
    get_resp("divu", 33, 32'd14);
    repeat (5) begin
      @(negedge clk);
      chk("hold", {resp_valid, req_ready, resp_data}, {2'b10, 32'd14});
    end
    ack();
    send(2'b01, 32'hFFFF_FFFF, 32'd16);
    chk("b2b_accept", t_acc - t_ack, 1);
    get_resp("b2b", 33, 32'h0FFF_FFFF);
    ack();
    // reset in the middle of a DIV
    send(2'b00, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    chk("mid_run", {busy, dact, load}, 3'b110);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    chk("arst_ctl", {resp_valid, load, dact, busy, req_ready}, 5'b00001);
    chk("arst_accum", accum, '0);
    // DIVU 5 / 9 = 0 (early-out candidate)
    send(2'b01, 32'd5, 32'd9);
    chk("early_load", load, EARLY_LOAD);
    get_resp("early", EARLY_LAT, 32'd0);
    ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_div_ctrl.md
# alu_div_ctrl

Sequencer for the RV32M restoring divider. Accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake, converts signed operands to magnitudes, and drives the divider unit's load, dact, sign, result-select and special-case controls. It owns the shift/subtract accumulator, resolves divide-by-zero and signed overflow locally, and returns the RISC-V-compliant result. It sits between the ALU issue logic and the divider unit.

## Interface
- W, 32, operand/result width
- C, 6, divider counter width; must satisfy 2^C > W
- clk  in  1  clock
- a_rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_a  in  W  dividend
- req_b  in  W  divisor
- resp_valid  out  1  result valid; high only in DONE
- resp_ready  in  1  consumer takes result
- resp_data  out  W  result; 0 outside DONE
- busy  out  1  state != IDLE
- load  out  1  to divider unit: counter load
- dact  out  1  to divider unit: divide active
- div_res_sel  out  1  to divider unit: 1 = remainder, equals req_op[1]
- div_sbit  out  2  to divider unit: [0] negate quotient, [1] negate remainder
- div_zero  out  1  to divider unit: divisor is zero
- div_overflow  out  1  to divider unit: signed overflow
- accum  out  2W+5  to divider unit: accumulator
- div_done  in  1  from divider unit: last iteration cycle
- div_result  in  W  from divider unit: sign-corrected result

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: req_ready=1. On req_valid, capture req_op, req_a and req_b, then go to LOAD.
- LOAD: load=1, dact=1.
  - signed = !op[0]; sa = signed & a[W-1]; sb = signed & b[W-1]. Magnitudes |a| and |b| are W-bit; 0x80000000 maps to 0x80000000 unsigned.
  - div_sbit[0] = sa^sb; div_sbit[1] = sa. Both are registered and held until IDLE.
  - div_zero = (b==0). div_overflow = signed & a==0x80000000 & b==0xFFFFFFFF. Both are registered and held until IDLE.
  - accum layout is {R[W+1:0], Q[W-1:0], 3'b000}. Initialise Q=|a| and R=0.
  - If div_zero or div_overflow, go to DONE. Otherwise go to RUN.
- RUN: dact=1. Each cycle performs one restoring step on the internal (W+1)-bit remainder r and Q:
  - t = {r[W-1:0],Q[W-1]} - |b|.
  - If t >= 0: r = t, Q = {Q[W-2:0],1}. Otherwise: r = {r[W-1:0],Q[W-1]}, Q = {Q[W-2:0],0}.
  - R field = {r,1'b0}, so the unit's rem = R>>1.
  - On the cycle div_done=1, perform the final step and go to DONE. div_done is ignored in LOAD.
- DONE: dact=0 and accum is frozen. resp_valid=1.
  - Normal case: resp_data = div_result.
  - div_zero: resp_data = 0xFFFFFFFF (quotient) or the original a (remainder).
  - div_overflow: resp_data = 0x80000000 (quotient) or 0 (remainder).
  - On resp_ready, go to IDLE.
- Leaving DONE clears div_zero, div_overflow and div_sbit. accum is cleared on the next accept.
- a_rst in any state returns to IDLE and zeroes all outputs and registers. req_ready reads 1 in the cycle after reset.

## Timing
- Reset values: req_ready=1 (after reset cycle). All other outputs are 0.
- Accept at edge T. LOAD occupies cycle T+1. RUN occupies cycles T+2..T+W+1 (W cycles). resp_valid rises at T+W+2, which is T+34 for W=32.
- Special cases: resp_valid rises at T+2.
- resp_data and resp_valid hold stable while resp_ready=0.
- Back-to-back operation: a response accepted at cycle D allows req_ready=1 at D+1. Minimum initiation interval is W+3 cycles.
- load is a single-cycle pulse per operation. No request is accepted while busy.

## Configuration
- ALU_DIV_EARLY_OUT_EN defined: in LOAD, if neither special case applies and |a| < |b|, go directly to DONE.
  - The result is quotient 0 or remainder a (sign preserved). resp_valid rises at T+2.
  - load stays 0 in that case; dact=1 for the LOAD cycle only.
- ALU_DIV_EARLY_OUT_EN undefined: every non-special operation runs all W iterations.

## Test plan
- DIV a=20, b=0xFFFFFFFD (-3) -> resp_data 0xFFFFFFFA at T+34. div_sbit=01 throughout.
- REM a=0xFFFFFFEC (-20), b=3 -> resp_data 0xFFFFFFFE at T+34. REMU 0xFFFFFFFF % 10 -> 5.
- DIVU a=7, b=0 -> div_zero=1 in LOAD, resp_data 0xFFFFFFFF at T+2. REM 7 % 0 -> 7.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+2. REM of the same operands -> 0.
- DIVU 100/7 with resp_ready held low for 5 cycles -> resp_data 14 held stable, req_ready=0 throughout. The next request is accepted the cycle after the handshake.
- a_rst asserted at T+10 of an active DIV -> IDLE next cycle, resp_valid=0, load=0, accum=0. A new DIVU 5/9 then returns 0: at T+2 with ALU_DIV_EARLY_OUT_EN, at T+34 without.
